// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and helpers for the SPI burst master.
//   spi_state_t : burst FSM states (IDLE, SETUP, SHIFT, HOLD, DONE)
//   SPI_READ / SPI_WRITE : encodings of the rw request bit
//   build_cmd() : assembles the command byte sent ahead of the data bytes
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } spi_state_t;

    localparam logic SPI_READ  = 1'b1;
    localparam logic SPI_WRITE = 1'b0;

    // Command byte is {rw, ms, addr[5:0]}. When auto-increment is enabled and
    // the burst carries more than one data byte, the MS bit is forced high so
    // the sensor advances its register pointer; otherwise addr[6] passes through.
    function automatic logic [7:0] build_cmd(
        input logic       rw,
        input logic [6:0] addr,
        input logic       auto_inc,
        input logic       multi_byte
    );
        logic ms_bit;
        ms_bit = (auto_inc && multi_byte) ? 1'b1 : addr[6];
        return {rw, ms_bit, addr[5:0]};
    endfunction

endpackage

// File: rtl/spi_half_period_timer.sv
// -----------------------------------------------------------------------------
// spi_half_period_timer
// Counts CLK_DIV system clocks per SPC level and reports which edge comes next.
//   clk, reset  : system clock, synchronous active-high reset
//   clear       : restart the count from 0 (asserted on burst accept)
//   run         : count only while the FSM is in SETUP/SHIFT/HOLD
//   spc_level   : current registered SPC level
//   fall_tick   : last cycle of a high level (FSM may drive SPC low next edge);
//                 also marks the end of SETUP and HOLD, where SPC is held high
//   rise_tick   : last cycle of a low level (FSM drives SPC high next edge)
// -----------------------------------------------------------------------------
module spi_half_period_timer #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    input  logic spc_level,
    output logic fall_tick,
    output logic rise_tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_reg;
    logic             cnt_last;

    assign cnt_last = (cnt_reg == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_reg <= '0;
        end else if (run) begin
            cnt_reg <= cnt_last ? '0 : cnt_reg + CNT_W'(1);
        end
    end

    assign fall_tick = run && cnt_last && spc_level;
    assign rise_tick = run && cnt_last && !spc_level;

endmodule

// File: rtl/spi_burst_master.sv
// -----------------------------------------------------------------------------
// spi_burst_master
// SPI mode-3 master for sensor register bursts. A request {rw, addr, len,
// wdata} is accepted in IDLE, a command byte plus len data bytes are shifted
// MSB first, and done pulses for one cycle at the end.
//   clk, reset : system clock, synchronous active-high reset
//   start      : request strobe, honoured only in IDLE with len != 0
//   rw         : 1 = read, 0 = write
//   addr       : 7-bit register address
//   len        : data byte count, saturated to MAX_BYTES
//   wdata      : write bytes, byte i at [8i+7:8i], byte 0 sent first
//   SDO        : serial data from slave
//   SPC, CS, SDI : registered serial clock, chip select (low), data to slave
//   rdata      : read bytes, same packing as wdata
//   busy, done : handshake status
// Build option: define SPI_AUTO_INC_EN to force the command MS bit on
// multi-byte bursts.
// -----------------------------------------------------------------------------
module spi_burst_master
    import spi_pkg::*;
#(
    parameter int MAX_BYTES = 12,
    parameter int CLK_DIV   = 1,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   rw,
    input  logic [6:0]             addr,
    input  logic [LEN_W-1:0]       len,
    input  logic [8*MAX_BYTES-1:0] wdata,
    input  logic                   SDO,
    output logic                   SPC,
    output logic                   CS,
    output logic                   SDI,
    output logic [8*MAX_BYTES-1:0] rdata,
    output logic                   busy,
    output logic                   done
);

    localparam int TOT_BITS = 8 * (MAX_BYTES + 1);
    // Bit index reaches 8*len+7, i.e. {len, 3'b111}
    localparam int BIT_W    = LEN_W + 3;

`ifdef SPI_AUTO_INC_EN
    localparam logic AUTO_INC = 1'b1;
`else
    localparam logic AUTO_INC = 1'b0;
`endif

    spi_state_t             state_reg, state_next;
    logic [BIT_W-1:0]       bit_cnt_reg, bit_cnt_next;
    logic [LEN_W-1:0]       len_reg, len_next;
    logic                   rw_reg, rw_next;
    logic [TOT_BITS-1:0]    tx_reg, tx_next, tx_load;
    logic                   spc_reg, spc_next;
    logic                   cs_reg, cs_next;
    logic                   sdi_reg, sdi_next;
    logic                   busy_reg, busy_next;
    logic                   done_reg, done_next;
    logic [8*MAX_BYTES-1:0] rdata_reg, rx_hit;

    logic                   accept;
    logic                   capture_en;
    logic                   fall_tick, rise_tick;
    logic                   timer_run;
    logic                   last_bit;
    logic [LEN_W-1:0]       len_eff;
    logic [7:0]             cmd_byte;
    logic [BIT_W-1:0]       data_idx;

    // ---------------------------------------------------------------- request
    assign len_eff  = (len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : len;
    assign cmd_byte = build_cmd(rw, addr, AUTO_INC, len_eff > LEN_W'(1));

    // Transmit image, MSB = first bit on the wire. Data bytes are zeroed on a
    // read so SDI idles low through the data phase without extra muxing.
    assign tx_load[TOT_BITS-1 -: 8] = cmd_byte;
    generate
        for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_tx_byte
            assign tx_load[TOT_BITS-9-8*gi -: 8] =
                (rw == SPI_WRITE) ? wdata[8*gi +: 8] : 8'h00;
        end
    endgenerate

    assign last_bit  = (bit_cnt_reg == {len_reg, 3'b111});
    assign data_idx  = bit_cnt_reg - BIT_W'(8);
    assign timer_run = (state_reg == SETUP) || (state_reg == SHIFT) ||
                       (state_reg == HOLD);

    spi_half_period_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (accept),
        .run       (timer_run),
        .spc_level (spc_reg),
        .fall_tick (fall_tick),
        .rise_tick (rise_tick)
    );

    // -------------------------------------------------------- FSM: registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            len_reg     <= '0;
            rw_reg      <= 1'b0;
            tx_reg      <= '0;
            spc_reg     <= 1'b1;
            cs_reg      <= 1'b1;
            sdi_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            len_reg     <= len_next;
            rw_reg      <= rw_next;
            tx_reg      <= tx_next;
            spc_reg     <= spc_next;
            cs_reg      <= cs_next;
            sdi_reg     <= sdi_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    // ---------------------------------------------- FSM: next state / outputs
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        len_next     = len_reg;
        rw_next      = rw_reg;
        tx_next      = tx_reg;
        spc_next     = spc_reg;
        cs_next      = cs_reg;
        sdi_next     = sdi_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        accept       = 1'b0;
        capture_en   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start && (len != '0)) begin
                    accept       = 1'b1;
                    state_next   = SETUP;
                    bit_cnt_next = '0;
                    len_next     = len_eff;
                    rw_next      = rw;
                    tx_next      = tx_load;
                    cs_next      = 1'b0;
                    spc_next     = 1'b1;
                    sdi_next     = cmd_byte[7];
                    busy_next    = 1'b1;
                end
            end

            SETUP: begin
                // First falling edge re-launches bit 0 (already on SDI) and
                // pops it from the transmit image.
                if (fall_tick) begin
                    state_next = SHIFT;
                    spc_next   = 1'b0;
                    sdi_next   = tx_reg[TOT_BITS-1];
                    tx_next    = {tx_reg[TOT_BITS-2:0], 1'b0};
                end
            end

            SHIFT: begin
                if (rise_tick) begin
                    spc_next   = 1'b1;
                    capture_en = (rw_reg == SPI_READ) &&
                                 (bit_cnt_reg >= BIT_W'(8));
                end else if (fall_tick) begin
                    if (last_bit) begin
                        state_next = HOLD;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                        spc_next     = 1'b0;
                        sdi_next     = tx_reg[TOT_BITS-1];
                        tx_next      = {tx_reg[TOT_BITS-2:0], 1'b0};
                    end
                end
            end

            HOLD: begin
                if (fall_tick) begin
                    state_next = DONE;
                    cs_next    = 1'b1;
                    sdi_next   = 1'b0;
                    done_next  = 1'b1;
                end
            end

            DONE: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end

            default: begin
                state_next = IDLE;
                cs_next    = 1'b1;
                spc_next   = 1'b1;
                sdi_next   = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------ read data
    // Data bit k (k = bit_cnt - 8) lands in byte k/8, bit 7 - k%8. Each rdata
    // bit decodes its own fixed k, so capture is a one-hot update.
    generate
        for (genvar gi = 0; gi < 8 * MAX_BYTES; gi++) begin : g_rx_bit
            localparam int DIDX = 8 * (gi / 8) + 7 - (gi % 8);
            assign rx_hit[gi] = capture_en && (data_idx == BIT_W'(DIDX));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || accept) begin
            rdata_reg <= '0;
        end else if (capture_en) begin
            rdata_reg <= (rdata_reg & ~rx_hit) | (rx_hit & {(8*MAX_BYTES){SDO}});
        end
    end

    assign SPC   = spc_reg;
    assign CS    = cs_reg;
    assign SDI   = sdi_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;
    assign rdata = rdata_reg;

endmodule

// File: tb/tb_spi_burst_master.sv
// -----------------------------------------------------------------------------
// tb_spi_burst_master
// Directed bench for spi_burst_master. Two instances share the request bus:
// dut1 with CLK_DIV=1, dut2 with CLK_DIV=3 (MAX_BYTES=12 on both). A simple
// mode-3 slave per instance shifts SDO from s_mem and records SDI bits.
// -----------------------------------------------------------------------------
module tb_spi_burst_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start1 = 1'b0, start2 = 1'b0;
    logic        rw = 1'b0;
    logic [6:0]  addr = '0;
    logic [3:0]  len = '0;
    logic [95:0] wdata = '0;

    logic        sdo1, spc1, cs1, sdi1, busy1, done1;
    logic        sdo2, spc2, cs2, sdi2, busy2, done2;
    logic [95:0] rdata1, rdata2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_burst_master #(.MAX_BYTES(12), .CLK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .rw(rw), .addr(addr),
        .len(len), .wdata(wdata), .SDO(sdo1), .SPC(spc1), .CS(cs1),
        .SDI(sdi1), .rdata(rdata1), .busy(busy1), .done(done1)
    );

    spi_burst_master #(.MAX_BYTES(12), .CLK_DIV(3)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .rw(rw), .addr(addr),
        .len(len), .wdata(wdata), .SDO(sdo2), .SPC(spc2), .CS(cs2),
        .SDI(sdi2), .rdata(rdata2), .busy(busy2), .done(done2)
    );

    // ------------------------------------------------------------- slaves
    logic [7:0] s_mem [0:15];
    int   s1_cnt = 0, s1_total = 0, s2_cnt = 0, s2_total = 0;
    logic mosi1 [0:127];
    logic mosi2 [0:127];

    always @(posedge spc1 or posedge cs1) begin
        if (cs1) begin
            if (s1_cnt != 0) s1_total <= s1_cnt;
            s1_cnt <= 0;
        end else begin
            if (s1_cnt < 128) mosi1[s1_cnt] <= sdi1;
            s1_cnt <= s1_cnt + 1;
        end
    end

    always @(posedge spc2 or posedge cs2) begin
        if (cs2) begin
            if (s2_cnt != 0) s2_total <= s2_cnt;
            s2_cnt <= 0;
        end else begin
            if (s2_cnt < 128) mosi2[s2_cnt] <= sdi2;
            s2_cnt <= s2_cnt + 1;
        end
    end

    // Bit b is presented before its rising edge, when b rises have been seen.
    assign sdo1 = (s1_cnt >= 8 && s1_cnt < 136) ?
                  s_mem[(s1_cnt-8)/8][7-((s1_cnt-8)%8)] : 1'b0;
    assign sdo2 = (s2_cnt >= 8 && s2_cnt < 136) ?
                  s_mem[(s2_cnt-8)/8][7-((s2_cnt-8)%8)] : 1'b0;

    function automatic logic [7:0] mosi_byte(input int sel, input int k);
        logic [7:0] v;
        for (int i = 0; i < 8; i++)
            v[7-i] = (sel == 0) ? mosi1[8*k+i] : mosi2[8*k+i];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one burst and measure it. Cycle 1 is the cycle after accept.
    // Returns in the cycle after the done pulse.
    task automatic run_burst(
        input  int          sel,
        input  logic        r,
        input  logic [6:0]  a,
        input  logic [3:0]  l,
        input  logic [95:0] wd,
        output int          done_cyc,
        output int          cs_low,
        output int          done_w,
        output int          low_runs,
        output int          min_low,
        output int          max_low
    );
        int   cyc, run;
        logic c, s, d;
        rw = r; addr = a; len = l; wdata = wd;
        if (sel == 0) start1 = 1'b1; else start2 = 1'b1;
        tick();
        start1 = 1'b0; start2 = 1'b0;
        cyc = 1; done_cyc = -1; cs_low = 0; done_w = 0;
        low_runs = 0; run = 0; min_low = 100000; max_low = 0;
        while (cyc < 3000) begin
            c = (sel == 0) ? cs1 : cs2;
            s = (sel == 0) ? spc1 : spc2;
            d = (sel == 0) ? done1 : done2;
            if (!c) cs_low++;
            if (!s) run++;
            else if (run > 0) begin
                low_runs++;
                if (run < min_low) min_low = run;
                if (run > max_low) max_low = run;
                run = 0;
            end
            if (d === 1'b1) begin
                done_w++;
                if (done_cyc < 0) done_cyc = cyc;
            end else if (done_cyc >= 0) begin
                break;
            end
            tick();
            cyc++;
        end
        checks++;
        if (done_cyc < 0) begin
            failures++;
            $display("FAIL burst_timeout sel=%0d: no done within %0d cycles", sel, cyc);
        end
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({cs1, spc1, sdi1, busy1, done1} !== 5'b11000) begin
            failures++;
            $display("FAIL reset_pins1: got cs,spc,sdi,busy,done=%b want 11000",
                     {cs1, spc1, sdi1, busy1, done1});
        end
        reset = 1'b0;
        tick();
        checks++;
        if (rdata1 !== 96'h0 || rdata2 !== 96'h0) begin
            failures++;
            $display("FAIL reset_rdata: got %h / %h want 0", rdata1, rdata2);
        end
        checks++;
        if ({cs2, spc2, sdi2, busy2, done2} !== 5'b11000) begin
            failures++;
            $display("FAIL reset_pins2: got %b want 11000", {cs2, spc2, sdi2, busy2, done2});
        end
        $display("test_reset done");
    endtask

    task automatic test_read_single();
        int dc, cl, dw, lr, mn, mx;
        s_mem[0] = 8'h33;
        run_burst(0, 1'b1, 7'h0F, 4'd1, 96'h0, dc, cl, dw, lr, mn, mx);
        checks++;
        if (dc != 35) begin failures++; $display("FAIL rd1_latency: got %0d want 35", dc); end
        checks++;
        if (cl != 34) begin failures++; $display("FAIL rd1_cs_low: got %0d want 34", cl); end
        checks++;
        if (mosi_byte(0, 0) !== 8'h8F) begin
            failures++; $display("FAIL rd1_cmd: got %h want 8f", mosi_byte(0, 0));
        end
        checks++;
        if (mosi_byte(0, 1) !== 8'h00) begin
            failures++; $display("FAIL rd1_sdi_zero: got %h want 00", mosi_byte(0, 1));
        end
        checks++;
        if (rdata1 !== 96'h33) begin
            failures++; $display("FAIL rd1_rdata: got %h want 33", rdata1);
        end
        checks++;
        if (busy1 !== 1'b0 || s1_total != 16) begin
            failures++;
            $display("FAIL rd1_end: busy=%b bits=%0d want busy=0 bits=16", busy1, s1_total);
        end
        $display("test_read_single: latency=%0d cs_low=%0d rdata=%h", dc, cl, rdata1[7:0]);
    endtask

    task automatic test_write_single();
        int dc, cl, dw, lr, mn, mx;
        run_burst(0, 1'b0, 7'h20, 4'd1, 96'h57, dc, cl, dw, lr, mn, mx);
        checks++;
        if (mosi_byte(0, 0) !== 8'h20 || mosi_byte(0, 1) !== 8'h57) begin
            failures++;
            $display("FAIL wr1_stream: got %h %h want 20 57", mosi_byte(0, 0), mosi_byte(0, 1));
        end
        checks++;
        if (rdata1 !== 96'h0) begin failures++; $display("FAIL wr1_rdata: got %h want 0", rdata1); end
        checks++;
        if (dw != 1) begin failures++; $display("FAIL wr1_done_width: got %0d want 1", dw); end
        checks++;
        if (dc != 35) begin failures++; $display("FAIL wr1_latency: got %0d want 35", dc); end
        $display("test_write_single: latency=%0d done_width=%0d", dc, dw);
    endtask

    task automatic test_read_div3();
        int dc, cl, dw, lr, mn, mx;
        logic [7:0] exp_cmd;
        for (int k = 0; k < 6; k++) s_mem[k] = 8'(k + 1);
`ifdef SPI_AUTO_INC_EN
        exp_cmd = 8'hE8;
`else
        exp_cmd = 8'hA8;
`endif
        run_burst(1, 1'b1, 7'h28, 4'd6, 96'h0, dc, cl, dw, lr, mn, mx);
        checks++;
        if (dc != 343) begin failures++; $display("FAIL div3_latency: got %0d want 343", dc); end
        checks++;
        if (rdata2 !== 96'h060504030201) begin
            failures++; $display("FAIL div3_rdata: got %h want 060504030201", rdata2);
        end
        checks++;
        if (lr != 56 || mn != 3 || mx != 3) begin
            failures++;
            $display("FAIL div3_spc_low: runs=%0d min=%0d max=%0d want 56/3/3", lr, mn, mx);
        end
        checks++;
        if (cl != 342) begin failures++; $display("FAIL div3_cs_low: got %0d want 342", cl); end
        checks++;
        if (mosi_byte(1, 0) !== exp_cmd) begin
            failures++; $display("FAIL div3_cmd: got %h want %h", mosi_byte(1, 0), exp_cmd);
        end
        $display("test_read_div3: latency=%0d rdata=%h", dc, rdata2[47:0]);
    endtask

    task automatic test_start_rules();
        int bad, n;
        s_mem[0] = 8'hC6;
        // len==0 request must be ignored entirely
        rw = 1'b0; addr = 7'h20; len = 4'd0; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (cs1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL len0_ignored: %0d bad cycles want 0", bad); end

        // Real write burst; a competing request mid-burst must be ignored
        rw = 1'b0; addr = 7'h20; len = 4'd1; wdata = 96'h57; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (9) tick();
        rw = 1'b1; addr = 7'h11; len = 4'd2; wdata = '1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 0;
        while (done1 !== 1'b1 && n < 500) begin tick(); n++; end
        checks++;
        if (done1 !== 1'b1) begin failures++; $display("FAIL rules_done1: done=%b want 1", done1); end

        // start held from the DONE cycle: ignored there, accepted the next cycle
        rw = 1'b1; addr = 7'h33; len = 4'd1; start1 = 1'b1;
        tick();
        checks++;
        if (busy1 !== 1'b0) begin failures++; $display("FAIL start_in_done: busy=%b want 0", busy1); end
        checks++;
        if (s1_total != 16 || mosi_byte(0, 0) !== 8'h20 || mosi_byte(0, 1) !== 8'h57) begin
            failures++;
            $display("FAIL busy_start_ignored: bits=%0d bytes=%h %h want 16 20 57",
                     s1_total, mosi_byte(0, 0), mosi_byte(0, 1));
        end
        tick();
        start1 = 1'b0;
        checks++;
        if (busy1 !== 1'b1) begin failures++; $display("FAIL accept_after_done: busy=%b want 1", busy1); end
        n = 0;
        while (done1 !== 1'b1 && n < 500) begin tick(); n++; end
        tick();
        checks++;
        if (mosi_byte(0, 0) !== 8'hB3 || rdata1 !== 96'hC6) begin
            failures++;
            $display("FAIL rules_burst2: cmd=%h rdata=%h want b3 c6", mosi_byte(0, 0), rdata1);
        end
        $display("test_start_rules: second burst cmd=%h rdata=%h", mosi_byte(0, 0), rdata1[7:0]);
    endtask

    task automatic test_reset_mid_burst();
        int dc, cl, dw, lr, mn, mx, seen;
        s_mem[0] = 8'hA5; s_mem[1] = 8'h5A; s_mem[2] = 8'hFF; s_mem[3] = 8'h3C;
        rw = 1'b1; addr = 7'h0F; len = 4'd4; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (29) tick();
        checks++;
        if (busy1 !== 1'b1 || rdata1 === 96'h0) begin
            failures++;
            $display("FAIL pre_abort: busy=%b rdata=%h want busy=1 rdata!=0", busy1, rdata1);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({cs1, spc1, sdi1, busy1} !== 4'b1100 || rdata1 !== 96'h0) begin
            failures++;
            $display("FAIL abort_state: cs,spc,sdi,busy=%b rdata=%h want 1100 0",
                     {cs1, spc1, sdi1, busy1}, rdata1);
        end
        seen = 0;
        for (int i = 0; i < 120; i++) begin
            if (done1 !== 1'b0 || cs1 !== 1'b1) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL abort_no_done: %0d active cycles want 0", seen); end
        run_burst(0, 1'b1, 7'h0F, 4'd2, 96'h0, dc, cl, dw, lr, mn, mx);
        checks++;
        if (rdata1 !== 96'h5AA5 || dc != 51) begin
            failures++;
            $display("FAIL after_abort: rdata=%h latency=%0d want 5aa5 51", rdata1, dc);
        end
        $display("test_reset_mid_burst: fresh rdata=%h latency=%0d", rdata1[15:0], dc);
    endtask

    task automatic test_long_burst();
        int dc, cl, dw, lr, mn, mx;
        logic [95:0] exp_rd;
        logic [7:0]  exp_cmd;
        for (int k = 0; k < 16; k++) s_mem[k] = 8'(8'h10 + k);
        for (int k = 0; k < 12; k++) exp_rd[8*k +: 8] = 8'(8'h10 + k);
        run_burst(0, 1'b1, 7'h68, 4'd15, 96'h0, dc, cl, dw, lr, mn, mx);
        checks++;
        if (s1_total != 104 || dc != 211) begin
            failures++;
            $display("FAIL sat_len: bits=%0d latency=%0d want 104 211", s1_total, dc);
        end
        checks++;
        if (mosi_byte(0, 0) !== 8'hE8) begin
            failures++; $display("FAIL cmd_68: got %h want e8", mosi_byte(0, 0));
        end
        checks++;
        if (rdata1 !== exp_rd) begin
            failures++; $display("FAIL sat_rdata: got %h want %h", rdata1, exp_rd);
        end
`ifdef SPI_AUTO_INC_EN
        exp_cmd = 8'hE8;
`else
        exp_cmd = 8'hA8;
`endif
        run_burst(0, 1'b1, 7'h28, 4'd15, 96'h0, dc, cl, dw, lr, mn, mx);
        checks++;
        if (mosi_byte(0, 0) !== exp_cmd) begin
            failures++; $display("FAIL cmd_28: got %h want %h", mosi_byte(0, 0), exp_cmd);
        end
        $display("test_long_burst: cmd=%h bits=%0d latency=%0d", mosi_byte(0, 0), s1_total, dc);
    endtask

    initial begin
        for (int k = 0; k < 16; k++) s_mem[k] = 8'h00;
        test_reset();
        test_read_single();
        test_write_single();
        test_read_div3();
        test_start_rules();
        test_reset_mid_burst();
        test_long_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
